esm_dep_tracker: RTL and testbench

Parametrised dependency-tracking scoreboard for the ESM front end. It accepts one decoded instruction per cycle into a free slot of a BS-entry instruction buffer and records register hazards against every older live slot. RAW hazards are always tracked; WAW and WAR tracking are selectable. Slots retire through a completion port, and the block publishes a per-slot ready mask that the issue logic consumes.

---
 rtl/esm_dep_tracker_if.sv | 31 +++
 rtl/esm_dep_tracker.sv | 129 ++++++++++++
 tb/tb_esm_dep_tracker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/esm_dep_tracker_if.sv
// Allocation, completion and status bundle of the dependency tracker.
// master = instruction/issue side, slave = tracker.
interface esm_dep_tracker_if #(
    parameter int INSTR_W = 32,
    parameter int BS      = 16
);
    localparam int IW = $clog2(BS);

    logic               alloc_valid;
    logic               alloc_ready;
    logic [INSTR_W-1:0] Instr_in;
    logic               ALUSrc;
    logic               RegWrite;
    logic [IW-1:0]      alloc_idx;
    logic               complete_valid;
    logic [IW-1:0]      complete_idx;
    logic [BS-1:0]      ready_positions;
    logic [IW:0]        count;
    logic               full;
    logic               empty;

    modport master (
        output alloc_valid, Instr_in, ALUSrc, RegWrite, complete_valid, complete_idx,
        input  alloc_ready, alloc_idx, ready_positions, count, full, empty
    );

    modport slave (
        input  alloc_valid, Instr_in, ALUSrc, RegWrite, complete_valid, complete_idx,
        output alloc_ready, alloc_idx, ready_positions, count, full, empty
    );
endinterface

// File: rtl/esm_dep_tracker.sv
// Register-hazard scoreboard: allocation and completion take effect at the next edge; status is from flops only.
// Backpressure: alloc_ready drops when every slot is live; allocations while full are dropped.
module esm_dep_tracker #(
    parameter int INSTR_W   = 32,
    parameter int REGNUM    = 32,
    parameter int BS        = 16,
    parameter bit TRACK_WAW = 1'b1,
    parameter bit TRACK_WAR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    esm_dep_tracker_if.slave io
);
    localparam int RA = $clog2(REGNUM);
    localparam int IW = $clog2(BS);

    logic [BS-1:0] live_q, live_d;
    logic [BS-1:0] uses_rs2_q, uses_rs2_d;
    logic [BS-1:0] writes_rd_q, writes_rd_d;
    logic [RA-1:0] rs1_q [BS];
    logic [RA-1:0] rs1_d [BS];
    logic [RA-1:0] rs2_q [BS];
    logic [RA-1:0] rs2_d [BS];
    logic [RA-1:0] rd_q  [BS];
    logic [RA-1:0] rd_d  [BS];
    logic [BS-1:0] dep_q [BS];
    logic [BS-1:0] dep_d [BS];

    logic [RA-1:0] rs1_new, rs2_new, rd_new;
    logic          uses_rs2_new, writes_rd_new;
    logic [BS-1:0] row_new;
    logic [BS-1:0] ready;
    logic [IW:0]   count;
    logic [IW-1:0] free_idx;
    logic          full, do_alloc, do_retire;
    logic          unused_instr;

    assign rd_new        = io.Instr_in[7 +: RA];
    assign rs1_new       = io.Instr_in[15 +: RA];
    assign rs2_new       = io.Instr_in[20 +: RA];
    assign uses_rs2_new  = !io.ALUSrc;
    assign writes_rd_new = io.RegWrite && (rd_new != '0);
    assign unused_instr  = ^io.Instr_in;

    // Descending scan leaves the lowest free index in free_idx.
    always_comb begin
        count    = '0;
        free_idx = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            count = count + {{IW{1'b0}}, live_q[i]};
            if (!live_q[i]) free_idx = IW'(i);
        end
    end

    assign full = (count == (IW + 1)'(BS));

    always_comb begin
        ready = '0;
        for (int i = 0; i < BS; i++) ready[i] = live_q[i] && (dep_q[i] == '0);
    end

    // A slot retiring this cycle is excluded so the newcomer never waits on it.
    always_comb begin
        row_new = '0;
        for (int j = 0; j < BS; j++) begin
            row_new[j] = live_q[j]
                && !(io.complete_valid && io.complete_idx == IW'(j))
                && ((writes_rd_q[j] && (rd_q[j] == rs1_new || (uses_rs2_new && rd_q[j] == rs2_new)))
                    || (TRACK_WAW && writes_rd_new && writes_rd_q[j] && rd_q[j] == rd_new)
                    || (TRACK_WAR && writes_rd_new
                        && (rs1_q[j] == rd_new || (uses_rs2_q[j] && rs2_q[j] == rd_new))));
        end
    end

    always_comb begin
        live_d      = live_q;
        uses_rs2_d  = uses_rs2_q;
        writes_rd_d = writes_rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        dep_d       = dep_q;
        do_retire   = io.complete_valid && live_q[io.complete_idx];
        do_alloc    = io.alloc_valid && !full;
        if (do_retire) begin
            live_d[io.complete_idx] = 1'b0;
            dep_d[io.complete_idx]  = '0;
            for (int i = 0; i < BS; i++) dep_d[i][io.complete_idx] = 1'b0;
        end
        if (do_alloc) begin
            live_d[free_idx]      = 1'b1;
            uses_rs2_d[free_idx]  = uses_rs2_new;
            writes_rd_d[free_idx] = writes_rd_new;
            rs1_d[free_idx]       = rs1_new;
            rs2_d[free_idx]       = rs2_new;
            rd_d[free_idx]        = rd_new;
            dep_d[free_idx]       = row_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            live_q      <= '0;
            uses_rs2_q  <= '0;
            writes_rd_q <= '0;
            for (int i = 0; i < BS; i++) begin
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                rd_q[i]  <= '0;
                dep_q[i] <= '0;
            end
        end else begin
            live_q      <= live_d;
            uses_rs2_q  <= uses_rs2_d;
            writes_rd_q <= writes_rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            dep_q       <= dep_d;
        end
    end

    assign io.alloc_ready     = !full;
    assign io.alloc_idx       = free_idx;
    assign io.count           = count;
    assign io.full            = full;
    assign io.empty           = (count == '0);
    assign io.ready_positions = ready;
endmodule

// File: tb/tb_esm_dep_tracker.sv
// Scoreboard bench: dut_a tracks RAW+WAW, dut_b tracks RAW+WAR; expected status snapshots are queued by the driver.
module tb_esm_dep_tracker;
    localparam logic [31:0] ADD3   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] SUB5   = 32'h404182B3; // sub  x5,x3,x4
    localparam logic [31:0] ADDI6  = 32'h00100313; // addi x6,x0,1
    localparam logic [31:0] ADDI0  = 32'h00100013; // addi x0,x0,1
    localparam logic [31:0] ADD300 = 32'h000001B3; // add  x3,x0,x0
    localparam logic [31:0] ADDI1  = 32'h00100093; // addi x1,x0,1

    typedef struct {
        int due;
        int sel;
        int rp;
        int cnt;
        int fl;
        int em;
        int ardy;
        int aidx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur;
    string cur_nm;

    esm_dep_tracker_if #(.INSTR_W(32), .BS(16)) ia ();
    esm_dep_tracker_if #(.INSTR_W(32), .BS(16)) ib ();

    esm_dep_tracker #(.TRACK_WAW(1'b1), .TRACK_WAR(1'b0)) dut_a (.clk(clk), .rst(rst), .io(ia));
    esm_dep_tracker #(.TRACK_WAW(1'b0), .TRACK_WAR(1'b1)) dut_b (.clk(clk), .rst(rst), .io(ib));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        if (req < 0) return;
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic check_dut(input exp_t e, input string nm, input int rp, input int cnt,
                             input int fl, input int em, input int ardy, input int aidx);
        chk({nm, ".ready_positions"}, rp, e.rp);
        chk({nm, ".count"}, cnt, e.cnt);
        chk({nm, ".full"}, fl, e.fl);
        chk({nm, ".empty"}, em, e.em);
        chk({nm, ".alloc_ready"}, ardy, e.ardy);
        chk({nm, ".alloc_idx"}, aidx, e.aidx);
    endtask

    // Monitor: snapshots are due in the cycle after the edge that produced them.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            cur    = exp_q.pop_front();
            cur_nm = name_q.pop_front();
            if (cur.sel == 0)
                check_dut(cur, cur_nm, int'(ia.ready_positions), int'(ia.count), int'(ia.full),
                          int'(ia.empty), int'(ia.alloc_ready), int'(ia.alloc_idx));
            else
                check_dut(cur, cur_nm, int'(ib.ready_positions), int'(ib.count), int'(ib.full),
                          int'(ib.empty), int'(ib.alloc_ready), int'(ib.alloc_idx));
        end
    end

    task automatic expect_st(input int sel, input string nm, input int rp, input int cnt,
                             input int fl, input int em, input int ardy, input int aidx);
        exp_t e;
        e.due = cyc; e.sel = sel; e.rp = rp; e.cnt = cnt;
        e.fl = fl; e.em = em; e.ardy = ardy; e.aidx = aidx;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic av, input logic [31:0] ins, input logic alu,
                         input logic rw, input logic cv, input logic [3:0] ci);
        if (sel == 0) begin
            ia.alloc_valid = av; ia.Instr_in = ins; ia.ALUSrc = alu; ia.RegWrite = rw;
            ia.complete_valid = cv; ia.complete_idx = ci;
        end else begin
            ib.alloc_valid = av; ib.Instr_in = ins; ib.ALUSrc = alu; ib.RegWrite = rw;
            ib.complete_valid = cv; ib.complete_idx = ci;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic op(input int sel, input logic av, input logic [31:0] ins, input logic alu,
                      input logic rw, input logic cv, input logic [3:0] ci);
        drive(sel, av, ins, alu, rw, cv, ci);
        tick();
        idle_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        idle_all();
        rst = 1'b0;
        tick();
        tick();
        expect_st(0, "rst_init_a", 0, 0, 0, 1, 1, 0);
        expect_st(1, "rst_init_b", 0, 0, 0, 1, 1, 0);
        rst = 1'b1;

        repeat (12) begin
            drive(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            drive(1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            tick();
        end
        drive(0, 1'b1, ADD3, 1'b0, 1'b1, 1'b1, 4'd2);
        drive(1, 1'b1, ADD3, 1'b0, 1'b1, 1'b1, 4'd2);
        rst = 1'b0;
        tick();
        idle_all();
        tick();
        expect_st(0, "rst_traffic_a", 0, 0, 0, 1, 1, 0);
        expect_st(1, "rst_traffic_b", 0, 0, 0, 1, 1, 0);
        rst = 1'b1;

        // RAW chain, then an ignored completion of a dead slot
        op(0, 1'b1, ADD3, 1'b0, 1'b1, 1'b0, 4'd0);
        expect_st(0, "raw_alloc0", 'h1, 1, 0, 0, 1, 1);
        op(0, 1'b1, SUB5, 1'b0, 1'b1, 1'b0, 4'd0);
        expect_st(0, "raw_alloc1", 'h1, 2, 0, 0, 1, 2);
        op(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd9);
        expect_st(0, "raw_nonlive", 'h1, 2, 0, 0, 1, 2);
        op(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
        expect_st(0, "raw_release", 'h2, 1, 0, 0, 1, 0);
        tick();
        expect_st(0, "raw_idle", 'h2, 1, 0, 0, 1, 0);

        // Fill, overflow attempt, hole at slot 7 and refill
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            op(1, 1'b1, ADDI6, 1'b1, 1'b1, 1'b0, 4'd0);
            expect_st(1, "full_fill", (1 << i) - 1, i, (i == 16) ? 1 : 0, 0,
                      (i < 16) ? 1 : 0, (i < 16) ? i : -1);
        end
        op(1, 1'b1, ADDI6, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_st(1, "full_overflow", 'hFFFF, 16, 1, 0, 0, -1);
        op(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd7);
        expect_st(1, "full_hole7", 'hFF7F, 15, 0, 0, 1, 7);
        op(1, 1'b1, ADDI6, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_st(1, "full_refill7", 'hFFFF, 16, 1, 0, 0, -1);

        // Same-cycle completion of the producer and allocation of its consumer
        do_reset();
        op(0, 1'b1, ADD3, 1'b0, 1'b1, 1'b0, 4'd0);
        expect_st(0, "sim_alloc0", 'h1, 1, 0, 0, 1, 1);
        op(0, 1'b1, SUB5, 1'b0, 1'b1, 1'b1, 4'd0);
        expect_st(0, "sim_both", 'h2, 1, 0, 0, 1, 0);

        // WAW enabled on dut_a, disabled on dut_b
        do_reset();
        op(0, 1'b1, ADDI6, 1'b1, 1'b1, 1'b0, 4'd0);
        op(0, 1'b1, ADDI6, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_st(0, "waw_on", 'h1, 2, 0, 0, 1, 2);
        op(1, 1'b1, ADDI6, 1'b1, 1'b1, 1'b0, 4'd0);
        op(1, 1'b1, ADDI6, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_st(1, "waw_off", 'h3, 2, 0, 0, 1, 2);

        // x0 never creates a hazard
        do_reset();
        op(0, 1'b1, ADDI0, 1'b1, 1'b1, 1'b0, 4'd0);
        op(0, 1'b1, ADD300, 1'b0, 1'b1, 1'b0, 4'd0);
        expect_st(0, "x0_free", 'h3, 2, 0, 0, 1, 2);

        // WAR on dut_b
        do_reset();
        op(1, 1'b1, ADD3, 1'b0, 1'b1, 1'b0, 4'd0);
        op(1, 1'b1, ADDI1, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_st(1, "war_wait", 'h1, 2, 0, 0, 1, 2);
        op(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
        expect_st(1, "war_release", 'h2, 1, 0, 0, 1, 0);

        tick();
        tick();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
